xtx_sequencer: RTL
==================

// Module: xtx_sequencer
// PURPOSE
//  Initiator side of the start/finished handshake used by the XtX compute engine.
//  Holds a small buffer of (X,Y) sample pairs loaded by the host, then issues one
//  engine transaction per sample and accumulates the returned results into acc_out.
//  Sits between the host load port and the XtX engine in the regression datapath.
// PARAMETERS
//  DW       32    sample and engine-result width
//  DEPTH    16    sample buffer entries (power of 2)
//  AW       4     log2(DEPTH)
//  ACC_W    48    accumulator width
//  TIMEOUT  64    maximum WAIT cycles per sample before abort
// PORTS
//  clk           in   1      single clock, rising edge
//  reset_n       in   1      synchronous, active-low reset
//  wr_en         in   1      host write strobe into sample buffer
//  wr_addr       in   AW     host write address
//  wr_x, wr_y    in   DW     sample pair to store
//  n_samples     in   AW+1   samples to process; sampled with go; values >DEPTH clamp to DEPTH
//  go            in   1      start a run (level, sampled only in IDLE)
//  busy          out  1      high from cycle after go is accepted until DONE exits
//  done          out  1      one-cycle pulse at end of run (normal or aborted)
//  err_timeout   out  1      sticky until next accepted go; set on engine timeout
//  acc_out       out  ACC_W  accumulated result, valid when done is high, held afterwards
//  eng_start     out  1      one-cycle start pulse to engine
//  eng_x, eng_y  out  DW     operands; stable from ISSUE through ACC
//  eng_finished  in   1      engine completion strobe
//  eng_result    in   DW     engine result, sampled in the cycle eng_finished is high
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=IDLE; busy, done, eng_start, err_timeout=0;
//   eng_x, eng_y, acc_out=0; index and timeout counters=0. Buffer contents not cleared.
//  All outputs are registered.
//  States:
//   IDLE  : go=1 -> clear acc and index, latch clamped n_samples; n=0 -> DONE, else LOAD.
//   LOAD  : drive buffer read address=index (1-cycle sync read) -> ISSUE.
//   ISSUE : eng_x/eng_y <= buffer data; eng_start=1 for this cycle only -> WAIT.
//   WAIT  : eng_finished=1 -> capture eng_result -> ACC.
//           Otherwise the counter increments; reaching TIMEOUT -> err_timeout=1 -> DONE.
//           When eng_finished and the timeout limit coincide, eng_finished wins.
//   ACC   : acc <= acc + zero-extended result (mod 2^ACC_W, wraps silently); index++;
//           index==n -> DONE, else LOAD.
//   DONE  : done=1, busy=0 on exit -> IDLE. acc_out keeps the partial sum on abort.
//  Per-sample cost is 3+L cycles, where L is the number of WAIT cycles including the
//   finished cycle.
//  go while busy: ignored. eng_finished outside WAIT: ignored. wr_en while busy:
//   dropped (buffer is read-stable during a run). wr_en in IDLE: written the same edge.
//  Reset mid-run: immediate return to IDLE; eng_start deasserted the following cycle.
// STRUCTURE
//  Package xtx_pkg: DW, ACC_W, TIMEOUT defaults, state encoding localparams.
//  One sub-module: xtx_sample_ram. Dual-port, one write port and one sync read port,
//   2*DW wide, DEPTH deep, no reset.
//  FSM, counters and accumulator stay in xtx_sequencer.
// TESTING  (engine model: finished 2 cycles after start, result = low DW bits of X*Y; L=2)
//  1. Load (1,2),(3,4),(5,6); n=3; go in cycle 0 -> 3 eng_start pulses; done during
//     cycle 16; acc_out=44; err_timeout=0.
//  2. n=0; go -> done one cycle after go is sampled; acc_out=0; no eng_start.
//  3. Engine never finishes; n=2 -> err_timeout=1, done after TIMEOUT WAIT cycles;
//     acc_out=0; next go clears err_timeout.
//  4. n=20 with DEPTH=16 -> exactly 16 eng_start pulses; index wraps correctly.
//  5. Stray eng_finished in IDLE, go pulses and wr_en during a run -> no state change;
//     buffer is unchanged and acc_out matches the reference sum.
//  6. Drop reset_n during WAIT of sample 1 -> next cycle IDLE, all outputs 0; a fresh
//     run gives the correct sum.

Source files
------------

// File: rtl/xtx_pkg.sv
// Shared defaults and FSM encoding for the XtX engine sequencer.
package xtx_pkg;

  localparam int XTX_DW      = 32;
  localparam int XTX_DEPTH   = 16;
  localparam int XTX_AW      = 4;
  localparam int XTX_ACC_W   = 48;
  localparam int XTX_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

endpackage

// File: rtl/xtx_sample_ram.sv
// Sample pair buffer: one write port, one registered read port, write-first on
// an address collision so a pair written in the go cycle is seen by the run.
module xtx_sample_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; contents survive reset_n and only the
  // host write port changes them, which keeps this mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/xtx_sequencer.sv
// Start/finished initiator for the XtX engine: walks the sample buffer, issues
// one engine transaction per pair and accumulates the results.
module xtx_sequencer
  import xtx_pkg::*;
#(
  parameter int DW      = XTX_DW,
  parameter int DEPTH   = XTX_DEPTH,
  parameter int AW      = XTX_AW,
  parameter int ACC_W   = XTX_ACC_W,
  parameter int TIMEOUT = XTX_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_x,
  input  logic [DW-1:0]    wr_y,
  input  logic [AW:0]      n_samples,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [ACC_W-1:0] acc_out,
  output logic             eng_start,
  output logic [DW-1:0]    eng_x,
  output logic [DW-1:0]    eng_y,
  input  logic             eng_finished,
  input  logic [DW-1:0]    eng_result
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

  state_t          state;
  logic [AW:0]     idx;
  logic [AW:0]     idx_inc;
  logic [AW:0]     n_lat;
  logic [AW:0]     n_req;
  logic [TCW-1:0]  tcnt;
  logic [DW-1:0]   res;
  logic [AW-1:0]   rd_addr;
  logic [2*DW-1:0] rd_data;
  logic            ram_we;

  assign idx_inc = idx + 1'b1;
  assign n_req   = (n_samples > N_MAX) ? N_MAX : n_samples;
  // The buffer is frozen for the whole run; only an idle sequencer accepts writes.
  assign ram_we  = wr_en && (state == S_IDLE);

  // Read address runs one step ahead so the pair is already in rd_data during
  // LOAD and can be registered onto eng_x/eng_y together with eng_start.
  always_comb begin
    // NOTE: default assignment first, so every path drives rd_addr and no
    // latch is inferred.
    rd_addr = idx[AW-1:0];
    if (state == S_IDLE)     rd_addr = '0;
    else if (state == S_ACC) rd_addr = idx_inc[AW-1:0];
  end

  xtx_sample_ram #(
    .W     (2*DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data ({wr_x, wr_y}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      acc_out     <= '0;
      eng_start   <= 1'b0;
      eng_x       <= '0;
      eng_y       <= '0;
      idx         <= '0;
      n_lat       <= '0;
      tcnt        <= '0;
      res         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            acc_out     <= '0;
            idx         <= '0;
            n_lat       <= n_req;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            if (n_req == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          eng_x     <= rd_data[2*DW-1:DW];
          eng_y     <= rd_data[DW-1:0];
          eng_start <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          eng_start <= 1'b0;
          tcnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A finish arriving on the last allowed cycle still counts.
          if (eng_finished) begin
            res   <= eng_result;
            state <= S_ACC;
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_ACC: begin
          acc_out <= acc_out + {{(ACC_W-DW){1'b0}}, res};
          idx     <= idx_inc;
          if (idx_inc == n_lat) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
